// File: rtl/cfeb_l1a_pkg.sv
// Shared widths, field offsets and the packed block-descriptor layout for the
// L1A block queue and its FWFT storage.
package cfeb_l1a_pkg;

   localparam int L1ANUM_W    = 6;
   localparam int NUM_ENTRY_W = L1ANUM_W + 1;
   localparam int BLK_ENTRY_W = 16;

   localparam int RADR_LSB        = 0;
   localparam int RADR_W          = 4;
   localparam int L1ABIN_LSB      = 4;
   localparam int L1ABIN_W        = 8;
   localparam int LCT_PHASE_BIT   = 12;
   localparam int SCND_BLK_BIT    = 13;
   localparam int SCND_SHARED_BIT = 14;
   localparam int DGSCAFULL_BIT   = 15;

   localparam int NUM_PHASE_BIT   = L1ANUM_W;

   // Declared MSB first so the member positions line up with the offsets above
   typedef struct packed {
      logic                dgscafull;
      logic                scnd_shared;
      logic                scnd_blk;
      logic                lct_phase;
      logic [L1ABIN_W-1:0] l1abin;
      logic [RADR_W-1:0]   radr;
   } blk_entry_t;

endpackage

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO: the head entry is driven combinationally from
// storage, with wrap-bit pointers that are optionally triplicated and voted.
module fwft_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int TMR   = 0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   WE,
   input  logic [WIDTH-1:0]       DIN,
   input  logic                   RE,
   output logic [WIDTH-1:0]       DOUT,
   output logic                   EMPTY,
   output logic                   FULL,
   output logic [$clog2(DEPTH):0] COUNT,
   output logic                   OVF,
   output logic                   UNF
);

   localparam int AW = $clog2(DEPTH);
   localparam int NC = (TMR != 0) ? 3 : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_q [NC];
   logic [AW:0]      rd_q [NC];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_nxt;
   logic [AW:0]      rd_nxt;
   logic             do_wr;
   logic             do_rd;

   generate
      if (NC == 3) begin : g_vote
         assign wr_ptr = (wr_q[0] & wr_q[1]) | (wr_q[0] & wr_q[2]) | (wr_q[1] & wr_q[2]);
         assign rd_ptr = (rd_q[0] & rd_q[1]) | (rd_q[0] & rd_q[2]) | (rd_q[1] & rd_q[2]);
      end else begin : g_single
         assign wr_ptr = wr_q[0];
         assign rd_ptr = rd_q[0];
      end
   endgenerate

   assign EMPTY = (wr_ptr == rd_ptr);
   assign FULL  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign COUNT = wr_ptr - rd_ptr;

   // A pop on a full queue frees the slot the simultaneous push needs
   assign do_rd = RE && !EMPTY;
   assign do_wr = WE && (!FULL || do_rd);
   assign OVF   = WE && FULL && !RE;
   assign UNF   = RE && EMPTY;

   assign wr_nxt = do_wr ? wr_ptr + {{AW{1'b0}}, 1'b1} : wr_ptr;
   assign rd_nxt = do_rd ? rd_ptr + {{AW{1'b0}}, 1'b1} : rd_ptr;
   assign DOUT   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NC; i++) begin
            wr_q[i] <= '0;
            rd_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NC; i++) begin
            wr_q[i] <= wr_nxt;
            rd_q[i] <= rd_nxt;
         end
      end
   end

   // Storage is cleared on reset so the head outputs return to zero
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_wr) begin
         mem[wr_ptr[AW-1:0]] <= DIN;
      end
   end

endmodule

// File: rtl/l1a_blk_queue.sv
// Block-descriptor queue and L1A-number queue feeding the SCA readout
// sequencer, with the L1A number counter and sticky error flags.
module l1a_blk_queue
   import cfeb_l1a_pkg::*;
#(
   parameter int BLK_DEPTH = 16,
   parameter int NUM_DEPTH = 32,
   parameter int TMR       = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       L1A_CNT_RST,
   input  logic       L1A,
   input  logic       L1A_PHASE_IN,
   input  logic       BLK_WE,
   input  logic [3:0] BLK_RADR,
   input  logic [7:0] BLK_L1ABIN,
   input  logic       BLK_LCT_PHASE,
   input  logic       BLK_SCND_BLK,
   input  logic       BLK_SCND_SHARED,
   input  logic       BLK_DGSCAFULL,
   input  logic       BLK_POP,
   input  logic       POPL1AN,
   output logic       L1AEMPTY,
   output logic [3:0] RADR,
   output logic [7:0] L1ABIN,
   output logic       LCT_PHASE,
   output logic       SCND_BLK,
   output logic       SCND_SHARED,
   output logic       DGSCAFULL,
   output logic [5:0] L1ANUM,
   output logic       L1A_PHASE,
   output logic       BLK_FULL,
   output logic       NUM_FULL,
   output logic [4:0] BLK_CNT,
   output logic [3:0] ERR
);

   logic [L1ANUM_W-1:0]      l1a_cnt;
   logic [L1ANUM_W-1:0]      l1a_cnt_nxt;
   blk_entry_t               blk_din;
   blk_entry_t               blk_dout;
   logic [NUM_ENTRY_W-1:0]   num_din;
   logic [NUM_ENTRY_W-1:0]   num_dout;
   logic [$clog2(BLK_DEPTH):0] blk_count;
   logic [$clog2(NUM_DEPTH):0] num_count_unused;
   logic                     blk_empty;
   logic                     num_empty_unused;
   logic                     blk_ovf;
   logic                     blk_unf;
   logic                     num_ovf;
   logic                     num_unf;

   // Clear takes effect before the increment, so a clear with L1A numbers it 1
   always_comb begin
      l1a_cnt_nxt = l1a_cnt;
      if (L1A_CNT_RST) l1a_cnt_nxt = '0;
      if (L1A)         l1a_cnt_nxt = l1a_cnt_nxt + L1ANUM_W'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) l1a_cnt <= '0;
      else     l1a_cnt <= l1a_cnt_nxt;
   end

   always_comb begin
      blk_din.radr        = BLK_RADR;
      blk_din.l1abin      = BLK_L1ABIN;
      blk_din.lct_phase   = BLK_LCT_PHASE;
      blk_din.scnd_blk    = BLK_SCND_BLK;
      blk_din.scnd_shared = BLK_SCND_SHARED;
      blk_din.dgscafull   = BLK_DGSCAFULL;
   end

   assign num_din = {L1A_PHASE_IN, l1a_cnt_nxt};

   fwft_fifo #(.WIDTH(BLK_ENTRY_W), .DEPTH(BLK_DEPTH), .TMR(TMR)) u_blk_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .WE    (BLK_WE),
      .DIN   (blk_din),
      .RE    (BLK_POP),
      .DOUT  (blk_dout),
      .EMPTY (blk_empty),
      .FULL  (BLK_FULL),
      .COUNT (blk_count),
      .OVF   (blk_ovf),
      .UNF   (blk_unf)
   );

   fwft_fifo #(.WIDTH(NUM_ENTRY_W), .DEPTH(NUM_DEPTH), .TMR(TMR)) u_num_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .WE    (L1A),
      .DIN   (num_din),
      .RE    (POPL1AN),
      .DOUT  (num_dout),
      .EMPTY (num_empty_unused),
      .FULL  (NUM_FULL),
      .COUNT (num_count_unused),
      .OVF   (num_ovf),
      .UNF   (num_unf)
   );

   assign L1AEMPTY    = blk_empty;
   assign RADR        = blk_dout.radr;
   assign L1ABIN      = blk_dout.l1abin;
   assign LCT_PHASE   = blk_dout.lct_phase;
   assign SCND_BLK    = blk_dout.scnd_blk;
   assign SCND_SHARED = blk_dout.scnd_shared;
   assign DGSCAFULL   = blk_dout.dgscafull;
   assign L1ANUM      = num_dout[L1ANUM_W-1:0];
   assign L1A_PHASE   = num_dout[NUM_PHASE_BIT];
   assign BLK_CNT     = 5'(blk_count);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) ERR <= '0;
      else     ERR <= ERR | {num_unf, num_ovf, blk_unf, blk_ovf};
   end

endmodule

// File: tb/tb_l1a_blk_queue.sv
// Scoreboard bench for l1a_blk_queue: directed stimulus pushes hand-computed
// head values, a negedge monitor compares them whenever a pop is presented.
module tb_l1a_blk_queue;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       L1A_CNT_RST = 1'b0;
   logic       L1A = 1'b0;
   logic       L1A_PHASE_IN = 1'b0;
   logic       BLK_WE = 1'b0;
   logic [3:0] BLK_RADR = '0;
   logic [7:0] BLK_L1ABIN = '0;
   logic       BLK_LCT_PHASE = 1'b0;
   logic       BLK_SCND_BLK = 1'b0;
   logic       BLK_SCND_SHARED = 1'b0;
   logic       BLK_DGSCAFULL = 1'b0;
   logic       BLK_POP = 1'b0;
   logic       POPL1AN = 1'b0;
   logic       L1AEMPTY;
   logic [3:0] RADR;
   logic [7:0] L1ABIN;
   logic       LCT_PHASE;
   logic       SCND_BLK;
   logic       SCND_SHARED;
   logic       DGSCAFULL;
   logic [5:0] L1ANUM;
   logic       L1A_PHASE;
   logic       BLK_FULL;
   logic       NUM_FULL;
   logic [4:0] BLK_CNT;
   logic [3:0] ERR;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_blk [$];
   logic [6:0]  exp_num [$];

   l1a_blk_queue dut (
      .CLK(CLK), .RST(RST), .L1A_CNT_RST(L1A_CNT_RST), .L1A(L1A),
      .L1A_PHASE_IN(L1A_PHASE_IN), .BLK_WE(BLK_WE), .BLK_RADR(BLK_RADR),
      .BLK_L1ABIN(BLK_L1ABIN), .BLK_LCT_PHASE(BLK_LCT_PHASE),
      .BLK_SCND_BLK(BLK_SCND_BLK), .BLK_SCND_SHARED(BLK_SCND_SHARED),
      .BLK_DGSCAFULL(BLK_DGSCAFULL), .BLK_POP(BLK_POP), .POPL1AN(POPL1AN),
      .L1AEMPTY(L1AEMPTY), .RADR(RADR), .L1ABIN(L1ABIN), .LCT_PHASE(LCT_PHASE),
      .SCND_BLK(SCND_BLK), .SCND_SHARED(SCND_SHARED), .DGSCAFULL(DGSCAFULL),
      .L1ANUM(L1ANUM), .L1A_PHASE(L1A_PHASE), .BLK_FULL(BLK_FULL),
      .NUM_FULL(NUM_FULL), .BLK_CNT(BLK_CNT), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] mkBlk(input logic [3:0] radr, input logic [7:0] bin,
                                         input logic lct, input logic scnd,
                                         input logic shared, input logic dg);
      return {dg, shared, scnd, lct, bin, radr};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // One clock of stimulus; strobes drop again just after the edge
   task automatic applyStimulus(input logic [15:0] blk, input logic we, input logic pop,
                                input logic l1a, input logic ph, input logic crst,
                                input logic popn);
      {BLK_DGSCAFULL, BLK_SCND_SHARED, BLK_SCND_BLK, BLK_LCT_PHASE, BLK_L1ABIN, BLK_RADR} = blk;
      BLK_WE = we; BLK_POP = pop; L1A = l1a; L1A_PHASE_IN = ph;
      L1A_CNT_RST = crst; POPL1AN = popn;
      @(posedge CLK); #1;
      BLK_WE = 1'b0; BLK_POP = 1'b0; L1A = 1'b0; L1A_CNT_RST = 1'b0; POPL1AN = 1'b0;
   endtask

   task automatic doReset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      exp_blk.delete();
      exp_num.delete();
      RST = 1'b0;
   endtask

   task automatic checkDrained(input string name);
      checkOutput({name, "_blk_drained"}, exp_blk.size(), 0);
      checkOutput({name, "_num_drained"}, exp_num.size(), 0);
   endtask

   // Monitor: the head presented during a pop cycle must match the scoreboard front
   always @(negedge CLK) begin
      if (!RST && BLK_POP) begin
         if (exp_blk.size() > 0) begin
            logic [15:0] e;
            e = exp_blk.pop_front();
            checkOutput("blk_empty_at_pop", L1AEMPTY, 0);
            checkOutput("blk_head",
                        {DGSCAFULL, SCND_SHARED, SCND_BLK, LCT_PHASE, L1ABIN, RADR}, e);
         end else if (!L1AEMPTY) begin
            checks++;
            failures++;
            $display("[TB] FAIL blk_unexpected_head actual=0x%0h expected=empty", RADR);
         end
      end
      if (!RST && POPL1AN && exp_num.size() > 0) begin
         logic [6:0] n;
         n = exp_num.pop_front();
         checkOutput("num_head", {L1A_PHASE, L1ANUM}, n);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] start");
      doReset();
      checkOutput("rst_empty", L1AEMPTY, 1);
      checkOutput("rst_head", {DGSCAFULL, SCND_SHARED, SCND_BLK, LCT_PHASE, L1ABIN, RADR}, 0);
      checkOutput("rst_num", {L1A_PHASE, L1ANUM}, 0);
      checkOutput("rst_flags", {BLK_FULL, NUM_FULL, BLK_CNT, ERR}, 0);

      // L1A numbering starts at 1 and phases follow the pulses
      $display("[TB] L1A number queue");
      exp_num.push_back({1'b1, 6'd1}); applyStimulus(16'h0, 0, 0, 1, 1, 0, 0);
      exp_num.push_back({1'b0, 6'd2}); applyStimulus(16'h0, 0, 0, 1, 0, 0, 0);
      exp_num.push_back({1'b1, 6'd3}); applyStimulus(16'h0, 0, 0, 1, 1, 0, 0);
      repeat (3) applyStimulus(16'h0, 0, 0, 0, 0, 0, 1);
      checkOutput("num_no_err", ERR, 4'b0000);
      applyStimulus(16'h0, 0, 0, 0, 0, 0, 1);
      checkOutput("num_empty_after_3", ERR, 4'b1000);
      checkDrained("t1");

      $display("[TB] block descriptors");
      doReset();
      checkOutput("blk_empty_before", L1AEMPTY, 1);
      exp_blk.push_back(mkBlk(4'd5, 8'h0E, 0, 0, 0, 0));
      applyStimulus(mkBlk(4'd5, 8'h0E, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
      checkOutput("blk_empty_after_wr", L1AEMPTY, 0);
      checkOutput("blk_radr_first", RADR, 5);
      checkOutput("blk_cnt_1", BLK_CNT, 1);
      exp_blk.push_back(mkBlk(4'd9, 8'h01, 0, 1, 0, 0));
      applyStimulus(mkBlk(4'd9, 8'h01, 0, 1, 0, 0), 1, 0, 0, 0, 0, 0);
      checkOutput("blk_cnt_2", BLK_CNT, 2);
      applyStimulus(16'h0, 0, 1, 0, 0, 0, 0);
      checkOutput("blk_radr_second", RADR, 9);
      applyStimulus(16'h0, 0, 1, 0, 0, 0, 0);
      checkOutput("blk_empty_end", {L1AEMPTY, BLK_CNT}, {1'b1, 5'd0});
      checkDrained("t2");

      $display("[TB] block overflow");
      doReset();
      for (int i = 1; i <= 16; i++) begin
         exp_blk.push_back(mkBlk(4'(i), 8'(i), i[0], 0, 0, 0));
         applyStimulus(mkBlk(4'(i), 8'(i), i[0], 0, 0, 0), 1, 0, 0, 0, 0, 0);
         if (i == 15) checkOutput("blk_not_full_15", BLK_FULL, 0);
      end
      checkOutput("blk_full_16", {BLK_FULL, BLK_CNT}, {1'b1, 5'd16});
      applyStimulus(mkBlk(4'hF, 8'hFF, 1, 1, 1, 1), 1, 0, 0, 0, 0, 0);
      checkOutput("blk_ovf_err", ERR, 4'b0001);
      checkOutput("blk_ovf_cnt", BLK_CNT, 16);
      repeat (16) applyStimulus(16'h0, 0, 1, 0, 0, 0, 0);
      checkOutput("blk_ovf_drained", L1AEMPTY, 1);
      checkDrained("t3");

      $display("[TB] full queue push and pop");
      doReset();
      for (int i = 1; i <= 16; i++) begin
         exp_blk.push_back(mkBlk(4'(16 - i), 8'(8'h40 + i), 0, 0, 1, 0));
         applyStimulus(mkBlk(4'(16 - i), 8'(8'h40 + i), 0, 0, 1, 0), 1, 0, 0, 0, 0, 0);
      end
      exp_blk.push_back(mkBlk(4'd3, 8'hAA, 1, 0, 0, 1));
      applyStimulus(mkBlk(4'd3, 8'hAA, 1, 0, 0, 1), 1, 1, 0, 0, 0, 0);
      checkOutput("full_rw_cnt", {BLK_FULL, BLK_CNT}, {1'b1, 5'd16});
      checkOutput("full_rw_err", ERR, 4'b0000);
      repeat (16) applyStimulus(16'h0, 0, 1, 0, 0, 0, 0);
      checkOutput("full_rw_empty", L1AEMPTY, 1);
      checkDrained("t4");

      $display("[TB] underflow");
      doReset();
      applyStimulus(16'h0, 0, 1, 0, 0, 0, 1);
      checkOutput("unf_err", ERR, 4'b1010);
      checkOutput("unf_state", {L1AEMPTY, BLK_CNT}, {1'b1, 5'd0});
      exp_blk.push_back(mkBlk(4'hC, 8'h5A, 0, 0, 1, 1));
      exp_num.push_back({1'b0, 6'd1});
      applyStimulus(mkBlk(4'hC, 8'h5A, 0, 0, 1, 1), 1, 0, 1, 0, 0, 0);
      checkOutput("unf_recover_radr", RADR, 4'hC);
      applyStimulus(16'h0, 0, 1, 0, 0, 0, 1);
      checkDrained("t5");

      $display("[TB] L1A counter wrap and clear");
      doReset();
      exp_num.push_back({1'b0, 6'd1});
      applyStimulus(16'h0, 0, 0, 1, 0, 0, 0);
      for (int i = 2; i <= 64; i++) begin
         exp_num.push_back({i[1], 6'(i)});
         applyStimulus(16'h0, 0, 0, 1, i[1], 0, 1);
      end
      applyStimulus(16'h0, 0, 0, 0, 0, 0, 1);
      exp_num.push_back({1'b0, 6'd1}); applyStimulus(16'h0, 0, 0, 1, 0, 0, 0);
      exp_num.push_back({1'b1, 6'd2}); applyStimulus(16'h0, 0, 0, 1, 1, 0, 0);
      exp_num.push_back({1'b1, 6'd1}); applyStimulus(16'h0, 0, 0, 1, 1, 1, 0);
      exp_num.push_back({1'b0, 6'd2}); applyStimulus(16'h0, 0, 0, 1, 0, 0, 0);
      repeat (4) applyStimulus(16'h0, 0, 0, 0, 0, 0, 1);
      checkOutput("wrap_no_err", ERR, 4'b0000);
      checkDrained("t6");

      $display("[TB] reset mid-operation");
      doReset();
      for (int i = 0; i < 8; i++) applyStimulus(mkBlk(4'(i + 1), 8'h80, 1, 1, 1, 1), 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) applyStimulus(16'h0, 0, 0, 1, 1, 0, 0);
      checkOutput("num_full_32", NUM_FULL, 1);
      applyStimulus(16'h0, 0, 0, 1, 1, 0, 0);
      checkOutput("num_ovf_err", ERR, 4'b0100);
      checkOutput("mid_cnt", BLK_CNT, 8);
      #2 RST = 1'b1;
      #1;
      checkOutput("async_rst_empty", L1AEMPTY, 1);
      checkOutput("async_rst_head", {DGSCAFULL, SCND_SHARED, SCND_BLK, LCT_PHASE, L1ABIN, RADR}, 0);
      checkOutput("async_rst_num", {L1A_PHASE, L1ANUM}, 0);
      checkOutput("async_rst_flags", {BLK_FULL, NUM_FULL, BLK_CNT, ERR}, 0);
      doReset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l1a_blk_queue.md
Name: l1a_blk_queue

Overview:
- Upstream feeder for the SCA readout sequencer.
- Queues SCA block descriptors that the SCA controller produces on each L1A match: block address, L1A-bin pattern, LCT phase, second-block flags and digitise-full.
- Runs a separate L1A-number queue, so the readout stage can pop one L1A number and phase per L1A bit it serialises.
- Both queues are first-word-fall-through: the head entry is always valid on the outputs while the queue is not empty.

Parameters:
- BLK_DEPTH, 16, number of block-descriptor entries (power of 2).
- NUM_DEPTH, 32, number of L1A-number entries (power of 2).
- TMR, 0, 1 triplicates the pointers and count registers with majority vote.

Ports:
- CLK  in  1  system clock; all logic is posedge.
- RST  in  1  asynchronous, active-high reset.
- L1A_CNT_RST  in  1  synchronous clear of the L1A number counter.
- L1A  in  1  one-cycle L1A pulse.
- L1A_PHASE_IN  in  1  phase of the current L1A, sampled with L1A.
- BLK_WE  in  1  write strobe for a block descriptor.
- BLK_RADR  in  4  SCA block address.
- BLK_L1ABIN  in  8  per-sample L1A-match pattern.
- BLK_LCT_PHASE  in  1  LCT phase of the block.
- BLK_SCND_BLK  in  1  block is the second of a pair.
- BLK_SCND_SHARED  in  1  second block is shared with the previous event.
- BLK_DGSCAFULL  in  1  digitiser full at allocation; block carries no data.
- BLK_POP  in  1  readout has accepted the head descriptor.
- POPL1AN  in  1  active-high pop of the head L1A number (legacy name).
- L1AEMPTY  out  1  block queue empty.
- RADR  out  4  head descriptor field.
- L1ABIN  out  8  head descriptor field.
- LCT_PHASE  out  1  head descriptor field.
- SCND_BLK  out  1  head descriptor field.
- SCND_SHARED  out  1  head descriptor field.
- DGSCAFULL  out  1  head descriptor field.
- L1ANUM  out  6  head L1A number.
- L1A_PHASE  out  1  head L1A phase.
- BLK_FULL  out  1  block queue full.
- NUM_FULL  out  1  number queue full.
- BLK_CNT  out  5  block-queue occupancy, 0..BLK_DEPTH.
- ERR  out  4  sticky flags: {num_underflow, num_overflow, blk_underflow, blk_overflow}.

Behaviour:
- Reset values:
  - L1AEMPTY=1; all head fields 0; L1ANUM=0; L1A_PHASE=0.
  - BLK_FULL=0; NUM_FULL=0; BLK_CNT=0; ERR=0.
  - Pointers 0; L1A counter 0.
- L1A counter (6-bit):
  - On L1A, the counter increments first and the incremented value is written into the number queue together with L1A_PHASE_IN. The first L1A after reset is therefore numbered 1.
  - Wraps 63 -> 0.
  - L1A_CNT_RST clears the counter. If L1A arrives in the same cycle, the entry is numbered 1 and the counter becomes 1.
- Writes:
  - A block write (BLK_WE) or number write (L1A) is stored on the rising edge.
  - The entry appears on the head outputs the next cycle if the queue was empty: write-to-visible latency is 1 cycle.
  - Empty flag, count and full flag all update in that same cycle.
- Pops:
  - A pop advances the read pointer.
  - The next entry appears on the outputs the following cycle.
  - The head outputs hold their value while the queue is empty; stale data is permitted, but consumers qualify it with L1AEMPTY.
- Simultaneous push and pop on a non-empty queue: both execute; count is unchanged.
- Simultaneous push and pop on an empty queue: the pop is ignored and flagged as underflow; the push executes.
- Full queue, write without pop: the write is dropped, the corresponding overflow ERR bit is set, and the pointers are unchanged.
- Full queue, write with pop: both execute; no overflow.
- Empty queue, pop: ignored; the underflow ERR bit is set.
- ERR bits clear only on RST.
- Pointers: binary, one extra wrap bit; full = same index, differing wrap bits.
- No internal handshake between the two queues. The block queue holds one entry per SCA block; the number queue holds one entry per L1A.
- Reset mid-operation: all contents are discarded and outputs return to reset values asynchronously.

Decomposition:
- Shared package cfeb_l1a_pkg holds:
  - BLK_ENTRY_W = 16 (4+8+1+1+1+1) and the field bit offsets;
  - NUM_ENTRY_W = 7;
  - L1ANUM_W = 6.
- One generic sub-module, fwft_fifo (params WIDTH, DEPTH, TMR), with ports CLK, RST, WE, DIN, RE, DOUT, EMPTY, FULL, COUNT, OVF, UNF.
  - Instantiated twice: once for block descriptors, once for L1A numbers.
  - The top level contains the L1A counter, field packing/unpacking and ERR aggregation.

Test Plan:
- Reset, then L1A x3 with phases 1,0,1; pop x3 -> L1ANUM/L1A_PHASE read 1/1, 2/0, 3/1; after the last pop the number queue is empty.
- Write descriptors RADR=5 L1ABIN=0x0E DGSCAFULL=0, then RADR=9 L1ABIN=0x01 SCND_BLK=1 -> L1AEMPTY falls 1 cycle after the first write with RADR=5 on the outputs; BLK_POP -> RADR=9 next cycle; second BLK_POP -> L1AEMPTY=1, BLK_CNT=0.
- 17 block writes with no pops (BLK_DEPTH=16) -> BLK_FULL=1 after 16; the 17th is dropped and ERR[0]=1; popping all 16 returns writes 1..16 in order.
- Full queue, BLK_WE and BLK_POP in the same cycle -> BLK_CNT stays 16, ERR[0] stays 0, the new entry is read last.
- BLK_POP and POPL1AN while empty -> ERR[1]=1 and ERR[3]=1, no pointer movement; a subsequent write reads back correctly.
- 64 L1As -> the 64th entry has L1ANUM=0 (wrap); L1A_CNT_RST together with L1A -> entry numbered 1. Assert RST with the queues half full -> all outputs return to reset values immediately.
